// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: shared types and frame constants for the mtm_alu serial link
package mtm_alu_pkg;
    typedef enum logic [2:0] {IDLE, TYPE, DATA, STOP, WAIT_IDLE} rx_state_t;
    localparam logic FRAME_START = 1'b0;
    localparam logic FRAME_STOP  = 1'b1;
    localparam logic FRAME_CMD   = 1'b1;
    localparam logic FRAME_DATA  = 1'b0;
    localparam int   FRAME_BITS  = 11;
endpackage

// File: rtl/mtm_alu_serial_rx_if.sv
// mtm_alu_serial_rx_if: serial input and packet record bundle of the receiver
interface mtm_alu_serial_rx_if #(parameter int MAX_BYTES = 8);
    localparam int CNT_W = $clog2(MAX_BYTES + 1);
    logic                   sin;
    logic                   pkt_valid;
    logic [8*MAX_BYTES-1:0] pkt_data;
    logic [CNT_W-1:0]       pkt_ndata;
    logic [7:0]             pkt_ctl;
    logic                   pkt_err_frame;
    logic                   pkt_err_ovf;
    modport master (output sin, input pkt_valid, pkt_data, pkt_ndata, pkt_ctl, pkt_err_frame, pkt_err_ovf);
    modport slave  (input sin, output pkt_valid, pkt_data, pkt_ndata, pkt_ctl, pkt_err_frame, pkt_err_ovf);
endinterface

// File: rtl/mtm_alu_frame_rx.sv
// mtm_alu_frame_rx: bit-level deframer; reports one byte per frame the cycle after its stop bit
module mtm_alu_frame_rx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sin_i,
    output logic       byte_valid_o,
    output logic [7:0] data_o,
    output logic       is_cmd_o,
    output logic       frame_err_o
);
    rx_state_t  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       cmd_q, cmd_d, vld_q, vld_d, err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            cmd_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // a low stop bit parks in WAIT_IDLE so it cannot be mistaken for a start bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        cmd_d   = cmd_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE:      state_d = (sin_i == FRAME_START) ? TYPE : IDLE;
            TYPE: begin
                cmd_d   = (sin_i == FRAME_CMD);
                cnt_d   = 3'd7;
                state_d = DATA;
            end
            DATA: begin
                data_d  = {data_q[6:0], sin_i};
                cnt_d   = cnt_q - 3'd1;
                state_d = (cnt_q == 3'd0) ? STOP : DATA;
            end
            STOP: begin
                vld_d   = 1'b1;
                err_d   = (sin_i != FRAME_STOP);
                state_d = (sin_i == FRAME_STOP) ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: state_d = sin_i ? IDLE : WAIT_IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign byte_valid_o = vld_q;
    assign data_o       = data_q;
    assign is_cmd_o     = cmd_q;
    assign frame_err_o  = err_q;
endmodule

// File: rtl/mtm_alu_serial_rx.sv
// mtm_alu_serial_rx: assembles deframed bytes into packets closed by a command byte
module mtm_alu_serial_rx #(
    parameter int MAX_BYTES = 8
) (
    input logic              clk,
    input logic              reset_n,
    mtm_alu_serial_rx_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BYTES + 1);
    localparam int W     = 8 * MAX_BYTES;

    logic             byte_valid, is_cmd, frame_err;
    logic [7:0]       rx_byte;
    logic [W-1:0]     acc_q, data_q;
    logic [CNT_W-1:0] cnt_q, ndata_q;
    logic [7:0]       ctl_q;
    logic             ferr_q, ovf_q, valid_q, err_frame_q, err_ovf_q;

    mtm_alu_frame_rx u_frame_rx (
        .clk          (clk),
        .reset_n      (reset_n),
        .sin_i        (bus.sin),
        .byte_valid_o (byte_valid),
        .data_o       (rx_byte),
        .is_cmd_o     (is_cmd),
        .frame_err_o  (frame_err)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            ndata_q     <= '0;
            ctl_q       <= '0;
            err_frame_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (byte_valid) begin
                if (frame_err) begin
                    ferr_q <= 1'b1;
                end else if (is_cmd) begin
                    valid_q     <= 1'b1;
                    data_q      <= acc_q;
                    ndata_q     <= cnt_q;
                    ctl_q       <= rx_byte;
                    err_frame_q <= ferr_q;
                    err_ovf_q   <= ovf_q;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    ferr_q      <= 1'b0;
                    ovf_q       <= 1'b0;
                end else if (cnt_q == CNT_W'(MAX_BYTES)) begin
                    ovf_q <= 1'b1;
                end else begin
                    acc_q <= {acc_q[W-9:0], rx_byte};
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.pkt_valid     = valid_q;
    assign bus.pkt_data      = data_q;
    assign bus.pkt_ndata     = ndata_q;
    assign bus.pkt_ctl       = ctl_q;
    assign bus.pkt_err_frame = err_frame_q;
    assign bus.pkt_err_ovf   = err_ovf_q;
endmodule

// File: tb/tb_mtm_alu_serial_rx.sv
// tb_mtm_alu_serial_rx: directed checks of packet assembly, latency, overflow, framing errors and reset
module tb_mtm_alu_serial_rx;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   pulse_cyc = -1;
    int   doubles = 0;
    int   stop_cyc = 0;
    logic prev_valid = 1'b0;

    mtm_alu_serial_rx_if #(.MAX_BYTES(8)) bus ();
    mtm_alu_serial_rx #(.MAX_BYTES(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.pkt_valid) begin
            pulses    <= pulses + 1;
            pulse_cyc <= cyc;
            if (prev_valid) doubles <= doubles + 1;
        end
        prev_valid <= bus.pkt_valid;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.sin = 1'b1;
        end
    endtask

    task automatic send_frame(input logic cmd, input logic [7:0] d, input logic stop, input int gap);
        logic [10:0] f;
        f = {1'b0, cmd, d, stop};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            bus.sin = f[i];
        end
        stop_cyc = cyc + 1;
        idle(gap);
    endtask

    task automatic test_reset;
        checks += 6;
        if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.pkt_valid); end
        if (bus.pkt_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.pkt_data); end
        if (bus.pkt_ndata !== 4'd0) begin errors++; $display("FAIL reset_ndata: got %0d expected 0", bus.pkt_ndata); end
        if (bus.pkt_ctl !== 8'h00) begin errors++; $display("FAIL reset_ctl: got %h expected 00", bus.pkt_ctl); end
        if (bus.pkt_err_frame !== 1'b0) begin errors++; $display("FAIL reset_err_frame: got %b expected 0", bus.pkt_err_frame); end
        if (bus.pkt_err_ovf !== 1'b0) begin errors++; $display("FAIL reset_err_ovf: got %b expected 0", bus.pkt_err_ovf); end
    endtask

    task automatic test_full_packet;
        int p0;
        p0 = pulses;
        for (int i = 1; i <= 8; i++) send_frame(1'b0, 8'(i), 1'b1, 2);
        send_frame(1'b1, 8'h00, 1'b1, 2);
        idle(2);
        checks += 7;
        if (pulses !== p0 + 1) begin errors++; $display("FAIL full_pulses: got %0d expected %0d", pulses - p0, 1); end
        if (pulse_cyc !== stop_cyc + 1) begin errors++; $display("FAIL full_latency: got cycle %0d expected %0d", pulse_cyc, stop_cyc + 1); end
        if (bus.pkt_data !== 64'h0102030405060708) begin errors++; $display("FAIL full_data: got %h expected 0102030405060708", bus.pkt_data); end
        if (bus.pkt_ndata !== 4'd8) begin errors++; $display("FAIL full_ndata: got %0d expected 8", bus.pkt_ndata); end
        if (bus.pkt_ctl !== 8'h00) begin errors++; $display("FAIL full_ctl: got %h expected 00", bus.pkt_ctl); end
        if (bus.pkt_err_frame !== 1'b0) begin errors++; $display("FAIL full_err_frame: got %b expected 0", bus.pkt_err_frame); end
        if (bus.pkt_err_ovf !== 1'b0) begin errors++; $display("FAIL full_err_ovf: got %b expected 0", bus.pkt_err_ovf); end
    endtask

    task automatic test_back_to_back;
        int p0;
        p0 = pulses;
        send_frame(1'b0, 8'hAA, 1'b1, 0);
        send_frame(1'b0, 8'h55, 1'b1, 0);
        send_frame(1'b1, 8'h81, 1'b1, 0);
        idle(3);
        checks += 5;
        if (pulses !== p0 + 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", pulses - p0); end
        if (pulse_cyc !== stop_cyc + 1) begin errors++; $display("FAIL b2b_latency: got cycle %0d expected %0d", pulse_cyc, stop_cyc + 1); end
        if (bus.pkt_data !== 64'h000000000000AA55) begin errors++; $display("FAIL b2b_data: got %h expected 000000000000aa55", bus.pkt_data); end
        if (bus.pkt_ndata !== 4'd2) begin errors++; $display("FAIL b2b_ndata: got %0d expected 2", bus.pkt_ndata); end
        if (bus.pkt_ctl !== 8'h81) begin errors++; $display("FAIL b2b_ctl: got %h expected 81", bus.pkt_ctl); end
    endtask

    task automatic test_overflow;
        int p0;
        p0 = pulses;
        for (int i = 0; i < 9; i++) send_frame(1'b0, 8'h11 + 8'(i), 1'b1, 1);
        send_frame(1'b1, 8'h01, 1'b1, 3);
        checks += 6;
        if (pulses !== p0 + 1) begin errors++; $display("FAIL ovf_pulses: got %0d expected 1", pulses - p0); end
        if (bus.pkt_data !== 64'h1112131415161718) begin errors++; $display("FAIL ovf_data: got %h expected 1112131415161718", bus.pkt_data); end
        if (bus.pkt_ndata !== 4'd8) begin errors++; $display("FAIL ovf_ndata: got %0d expected 8", bus.pkt_ndata); end
        if (bus.pkt_err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus.pkt_err_ovf); end
        send_frame(1'b0, 8'h05, 1'b1, 1);
        send_frame(1'b1, 8'h03, 1'b1, 3);
        if (bus.pkt_err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b expected 0", bus.pkt_err_ovf); end
        if (bus.pkt_ndata !== 4'd1) begin errors++; $display("FAIL ovf_next_ndata: got %0d expected 1", bus.pkt_ndata); end
    endtask

    task automatic test_frame_err;
        int p0;
        p0 = pulses;
        send_frame(1'b0, 8'h33, 1'b0, 0);
        repeat (3) begin
            @(negedge clk);
            bus.sin = 1'b0;
        end
        idle(1);
        send_frame(1'b0, 8'h44, 1'b1, 1);
        send_frame(1'b1, 8'h02, 1'b1, 3);
        checks += 6;
        if (pulses !== p0 + 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", pulses - p0); end
        if (bus.pkt_ndata !== 4'd1) begin errors++; $display("FAIL ferr_ndata: got %0d expected 1", bus.pkt_ndata); end
        if (bus.pkt_data !== 64'h44) begin errors++; $display("FAIL ferr_data: got %h expected 0000000000000044", bus.pkt_data); end
        if (bus.pkt_ctl !== 8'h02) begin errors++; $display("FAIL ferr_ctl: got %h expected 02", bus.pkt_ctl); end
        if (bus.pkt_err_frame !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", bus.pkt_err_frame); end
        if (bus.pkt_err_ovf !== 1'b0) begin errors++; $display("FAIL ferr_ovf: got %b expected 0", bus.pkt_err_ovf); end
    endtask

    task automatic test_cmd_only;
        int p0;
        p0 = pulses;
        send_frame(1'b1, 8'hFF, 1'b1, 3);
        checks += 5;
        if (pulses !== p0 + 1) begin errors++; $display("FAIL cmd_pulses: got %0d expected 1", pulses - p0); end
        if (bus.pkt_ndata !== 4'd0) begin errors++; $display("FAIL cmd_ndata: got %0d expected 0", bus.pkt_ndata); end
        if (bus.pkt_data !== 64'h0) begin errors++; $display("FAIL cmd_data: got %h expected 0", bus.pkt_data); end
        if (bus.pkt_ctl !== 8'hFF) begin errors++; $display("FAIL cmd_ctl: got %h expected ff", bus.pkt_ctl); end
        if (bus.pkt_err_frame !== 1'b0) begin errors++; $display("FAIL cmd_err_frame: got %b expected 0", bus.pkt_err_frame); end
    endtask

    task automatic test_reset_midframe;
        int p0;
        logic [7:0] f;
        p0 = pulses;
        f  = {1'b0, 1'b0, 6'b101001};
        send_frame(1'b0, 8'h12, 1'b1, 1);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            bus.sin = f[i];
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.sin = 1'b1;
        idle(4);
        checks += 8;
        if (pulses !== p0) begin errors++; $display("FAIL rst_no_pulse: got %0d expected 0", pulses - p0); end
        if (bus.pkt_ndata !== 4'd0) begin errors++; $display("FAIL rst_ndata_cleared: got %0d expected 0", bus.pkt_ndata); end
        send_frame(1'b1, 8'h07, 1'b1, 3);
        if (pulses !== p0 + 1) begin errors++; $display("FAIL rst_next_pulses: got %0d expected 1", pulses - p0); end
        if (bus.pkt_ndata !== 4'd0) begin errors++; $display("FAIL rst_next_ndata: got %0d expected 0", bus.pkt_ndata); end
        if (bus.pkt_data !== 64'h0) begin errors++; $display("FAIL rst_next_data: got %h expected 0", bus.pkt_data); end
        if (bus.pkt_ctl !== 8'h07) begin errors++; $display("FAIL rst_next_ctl: got %h expected 07", bus.pkt_ctl); end
        if (bus.pkt_err_frame !== 1'b0) begin errors++; $display("FAIL rst_next_err_frame: got %b expected 0", bus.pkt_err_frame); end
        if (bus.pkt_err_ovf !== 1'b0) begin errors++; $display("FAIL rst_next_err_ovf: got %b expected 0", bus.pkt_err_ovf); end
    endtask

    initial begin
        bus.sin = 1'b1;
        repeat (3) @(negedge clk);
        test_reset;
        reset_n = 1'b1;
        idle(2);
        test_full_packet;
        test_back_to_back;
        test_overflow;
        test_frame_err;
        test_cmd_only;
        test_reset_midframe;
        checks++;
        if (doubles !== 0) begin errors++; $display("FAIL pulse_width: got %0d multi-cycle pulses expected 0", doubles); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
